// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit:
// state encodings, opcodes, func codes, ALU and PC-source selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR = 6'h08;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_FUNC = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_LUI  = 3'b110;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  function automatic logic [2:0] imm_alu_op(
    input logic [5:0] op
  );
    logic [2:0] r;
    r = ALU_ADD;
    unique case (1'b1)
      op == OP_SLTI: r = ALU_SLT;
      op == OP_ANDI: r = ALU_AND;
      op == OP_ORI:  r = ALU_OR;
      op == OP_LUI:  r = ALU_LUI;
      default:       r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational opcode dispatch and next-state logic.
// Ports: state_i, opcode_i, func_i, mem_ready_i, wait_i -> state_o.
module mc_next_state
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  input  logic       mem_ready_i,
  input  logic [3:0] wait_i,
  output state_e     state_o
);

  logic timeout;
  logic is_r;
  logic is_jr;
  logic is_i;

  // ready on the limit cycle wins over timeout
  assign timeout = !mem_ready_i &&
                   (wait_i == 4'(MEM_WAIT_MAX));
  assign is_r  = opcode_i == OP_RTYPE;
  assign is_jr = is_r && (func_i == FN_JR);
  assign is_i  = opcode_i inside {OP_ADDI, OP_SLTI,
                 OP_ANDI, OP_ORI, OP_LUI};

  always_comb begin
    state_o = state_i;
    unique case (state_i)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready_i) begin
          unique case (state_i)
            S_FETCH:  state_o = S_DECODE;
            S_MEM_RD: state_o = S_MEM_WB;
            default:  state_o = S_FETCH;
          endcase
        end else if (timeout) begin
          state_o = S_TRAP;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_jr:            state_o = S_JR;
          is_r && !is_jr:   state_o = S_R_EXEC;
          opcode_i == OP_J:   state_o = S_JUMP;
          opcode_i == OP_JAL: state_o = S_JAL;
          opcode_i == OP_BEQ ||
          opcode_i == OP_BNE: state_o = S_BRANCH;
          is_i:             state_o = S_I_EXEC;
          opcode_i == OP_LW ||
          opcode_i == OP_SW:  state_o = S_MEM_ADDR;
          default:          state_o = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        unique case (1'b1)
          opcode_i == OP_LW: state_o = S_MEM_RD;
          opcode_i == OP_SW: state_o = S_MEM_WR;
          default:           state_o = S_TRAP;
        endcase
      end
      S_R_EXEC: state_o = S_R_WB;
      S_I_EXEC: state_o = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH,
      S_JUMP, S_JAL, S_JR: state_o = S_FETCH;
      S_TRAP:   state_o = S_TRAP;
      default:  state_o = S_TRAP;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: state/wait/trap registers and
// Moore output decode. Ports: clk, rst_n, opcode, func, zero,
// mem_ready in; memory, register, ALU, PC strobes, trap, state out.
module mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       trap,
  output logic [3:0] state
);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] wait_q;
  logic [3:0] wait_d;
  logic       trap_d;
  logic       trap_q;
  logic       mem_st;

  mc_next_state #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_next (
    .state_i    (state_q),
    .opcode_i   (opcode),
    .func_i     (func),
    .mem_ready_i(mem_ready),
    .wait_i     (wait_q),
    .state_o    (state_d)
  );

  assign mem_st = state_q inside {S_FETCH,
                  S_MEM_RD, S_MEM_WR};

  // counts stall cycles; any entry into a memory
  // state arrives from a different state, so it restarts at 0
  assign wait_d = (mem_st && state_d == state_q) ?
                  wait_q + 4'd1 : 4'd0;
  assign trap_d = trap_q || (state_d == S_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= 4'd0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
    end
  end

  assign state = state_q;
  assign trap  = trap_q;

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = RD_RT;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PC_ALU;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM4;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNC;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = RD_RD;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_alu_op(opcode);
      end
      S_I_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_source     = PC_ALUOUT;
        pc_write_cond = 1'b1;
        // beq takes on zero, bne on not-zero
        pc_write = (opcode == OP_BEQ) ? zero : !zero;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_JUMP;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        pc_source = PC_JUMP;
        reg_write = 1'b1;
        reg_dst   = RD_RA;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = PC_REG;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed scoreboard bench for mc_controller: expected state and
// control word pushed per step, popped and compared after the edge.
module tb_mc_controller;

  localparam int MAXW = 15;

  localparam logic [3:0] FE  = 4'd0;
  localparam logic [3:0] DE  = 4'd1;
  localparam logic [3:0] MA  = 4'd2;
  localparam logic [3:0] MR  = 4'd3;
  localparam logic [3:0] MWB = 4'd4;
  localparam logic [3:0] MWR = 4'd5;
  localparam logic [3:0] RE  = 4'd6;
  localparam logic [3:0] RW  = 4'd7;
  localparam logic [3:0] BR  = 4'd8;
  localparam logic [3:0] JP  = 4'd9;
  localparam logic [3:0] IE  = 4'd10;
  localparam logic [3:0] IW  = 4'd11;
  localparam logic [3:0] JL  = 4'd12;
  localparam logic [3:0] JRS = 4'd13;
  localparam logic [3:0] TR  = 4'd15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic [1:0] reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       trap;
  logic [3:0] state;

  mc_controller #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .func         (func),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .iord         (iord),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source    (pc_source),
    .trap         (trap),
    .state        (state)
  );

  always #5 clk = ~clk;

  logic [22:0] sb[$];
  int vecs = 0;
  int errs = 0;

  // reference control word for a state, taken from the
  // per-state output table of the controller description
  function automatic logic [18:0] model(
    input logic [3:0] s,
    input logic [5:0] op,
    input logic       z,
    input logic       rdy,
    input logic       tr
  );
    logic mrd, mwr, iod, irw, rgw, m2r, asa, pw, pwc;
    logic [1:0] rd, asb, ps;
    logic [2:0] ao;
    mrd = 0; mwr = 0; iod = 0; irw = 0; rgw = 0;
    m2r = 0; asa = 0; pw = 0; pwc = 0;
    rd = 2'b00; asb = 2'b00; ps = 2'b00; ao = 3'b000;
    case (s)
      FE: begin
        mrd = 1; asb = 2'b01; irw = rdy; pw = rdy;
      end
      DE: asb = 2'b11;
      MA: begin asa = 1; asb = 2'b10; end
      MR: begin iod = 1; mrd = 1; end
      MWR: begin iod = 1; mwr = 1; end
      MWB: begin rgw = 1; m2r = 1; end
      RE: begin asa = 1; ao = 3'b010; end
      RW: begin rgw = 1; rd = 2'b01; end
      IE: begin
        asa = 1; asb = 2'b10;
        case (op)
          6'h0A: ao = 3'b101;
          6'h0C: ao = 3'b011;
          6'h0D: ao = 3'b100;
          6'h0F: ao = 3'b110;
          default: ao = 3'b000;
        endcase
      end
      IW: rgw = 1;
      BR: begin
        asa = 1; ao = 3'b001; ps = 2'b01; pwc = 1;
        pw = (op == 6'h04) ? z : ~z;
      end
      JP: begin pw = 1; ps = 2'b10; end
      JL: begin pw = 1; ps = 2'b10; rgw = 1; rd = 2'b10; end
      JRS: begin pw = 1; ps = 2'b11; end
      default: ;
    endcase
    return {mrd, mwr, iod, irw, rgw, m2r, rd, asa, asb,
            ao, pw, pwc, ps, tr};
  endfunction

  // expected word pushed when the step's inputs are driven,
  // compared 1 ns later, then advance to the next falling edge
  task automatic step(
    input logic [3:0] es,
    input logic       et,
    input string      tag
  );
    logic [22:0] e;
    logic [22:0] o;
    sb.push_back({es, model(es, opcode, zero, mem_ready, et)});
    #1;
    o = {state, mem_read, mem_write, iord, ir_write,
         reg_write, mem_to_reg, reg_dst, alu_src_a,
         alu_src_b, alu_op, pc_write, pc_write_cond,
         pc_source, trap};
    e = sb.pop_front();
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; opcode = 6'h00; func = 6'h00;
    zero = 0; mem_ready = 1;
    #2;
    step(FE, 0, "reset");
    rst_n = 1;

    // add: R-type path
    opcode = 6'h00; func = 6'h20;
    step(FE, 0, "add_fe"); step(DE, 0, "add_de");
    step(RE, 0, "add_re"); step(RW, 0, "add_rw");

    // lw with 3 stall cycles in MEM_RD
    opcode = 6'h23;
    step(FE, 0, "lw_fe"); step(DE, 0, "lw_de");
    step(MA, 0, "lw_ma");
    mem_ready = 0;
    for (int i = 0; i < 3; i++) step(MR, 0, "lw_stall");
    mem_ready = 1;
    step(MR, 0, "lw_done"); step(MWB, 0, "lw_wb");

    // beq / bne with both zero values
    for (int i = 0; i < 4; i++) begin
      opcode = (i < 2) ? 6'h04 : 6'h05;
      zero = (i % 2 == 0);
      step(FE, 0, "br_fe"); step(DE, 0, "br_de");
      step(BR, 0, "br_ex");
    end
    zero = 0;

    // jumps
    opcode = 6'h02;
    step(FE, 0, "j_fe"); step(DE, 0, "j_de");
    step(JP, 0, "j_ex");
    opcode = 6'h03;
    step(FE, 0, "jal_fe"); step(DE, 0, "jal_de");
    step(JL, 0, "jal_ex");
    opcode = 6'h00; func = 6'h08;
    step(FE, 0, "jr_fe"); step(DE, 0, "jr_de");
    step(JRS, 0, "jr_ex");

    // immediate ALU ops
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: opcode = 6'h08;
        1: opcode = 6'h0A;
        2: opcode = 6'h0C;
        3: opcode = 6'h0D;
        default: opcode = 6'h0F;
      endcase
      step(FE, 0, "imm_fe"); step(DE, 0, "imm_de");
      step(IE, 0, "imm_ex"); step(IW, 0, "imm_wb");
    end

    // fetch stall holds with no IR/PC write
    mem_ready = 0;
    step(FE, 0, "fe_stall"); step(FE, 0, "fe_stall");
    mem_ready = 1;

    // sw: ready arrives on the limit cycle -> completes
    opcode = 6'h2B;
    step(FE, 0, "swl_fe"); step(DE, 0, "swl_de");
    step(MA, 0, "swl_ma");
    mem_ready = 0;
    for (int i = 0; i < MAXW; i++) step(MWR, 0, "swl_stall");
    mem_ready = 1;
    step(MWR, 0, "swl_limit");
    step(FE, 0, "swl_next");

    // sw: ready never arrives -> trap
    step(DE, 0, "swt_de"); step(MA, 0, "swt_ma");
    mem_ready = 0;
    for (int i = 0; i < MAXW; i++) step(MWR, 0, "swt_stall");
    step(MWR, 0, "swt_limit");
    step(TR, 1, "swt_trap"); step(TR, 1, "swt_hold");

    // asynchronous reset out of TRAP
    rst_n = 0;
    step(FE, 0, "swt_rst");
    rst_n = 1; mem_ready = 1;

    // illegal opcode
    opcode = 6'h3F;
    step(FE, 0, "ill_fe"); step(DE, 0, "ill_de");
    step(TR, 1, "ill_trap"); step(TR, 1, "ill_hold");
    step(TR, 1, "ill_hold");
    rst_n = 0;
    step(FE, 0, "ill_rst");
    rst_n = 1;

    // reset mid-access abandons the load
    opcode = 6'h23;
    step(FE, 0, "ab_fe"); step(DE, 0, "ab_de");
    step(MA, 0, "ab_ma");
    mem_ready = 0;
    step(MR, 0, "ab_rd"); step(MR, 0, "ab_rd");
    rst_n = 0;
    step(FE, 0, "ab_rst");
    rst_n = 1; mem_ready = 1;
    opcode = 6'h00; func = 6'h22;
    step(FE, 0, "ab_fe2"); step(DE, 0, "ab_de2");
    step(RE, 0, "ab_re2"); step(RW, 0, "ab_rw2");
    step(FE, 0, "ab_end");

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
